// File: rtl/wb_req_master_pkg.sv
// Shared types for wb_req_master: FSM state encoding and response status constants.
package wb_req_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_BACKOFF,
        S_RESP
    } state_t;

    localparam logic        RSP_OK       = 1'b0;
    localparam logic        RSP_ERR      = 1'b1;
    localparam logic [31:0] RSP_DAT_NONE = 32'h0;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_req_master_if.sv
// Request/response handshake plus Wishbone pipelined master bus of wb_req_master.
interface wb_req_master_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [ADDR_WIDTH-1:0] req_adr_i;
    logic [3:0]            req_sel_i;
    logic [31:0]           req_dat_i;

    logic                  rsp_valid_o;
    logic                  rsp_err_o;
    logic [31:0]           rsp_dat_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [3:0]            wb_sel_o;
    logic [31:0]           wb_dat_o;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;
    logic [31:0]           wb_dat_i;

    modport master (
        input  req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        output req_ready_o,
        output rsp_valid_o, rsp_err_o, rsp_dat_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_err_o, rsp_dat_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

endinterface

// File: rtl/wb_req_timer.sv
// wb_req_timer: per-attempt cycle watchdog, built only with WB_REQ_MASTER_TIMEOUT_EN.
// Latency: expired rises combinationally in the TIMEOUT-th enabled cycle since clear.
// Backpressure: none; the count freezes once expired until the next clear.
module wb_req_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    // The current enabled cycle counts toward the limit, hence TIMEOUT-1.
    assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/wb_req_master.sv
// wb_req_master: one request at a time onto a Wishbone pipelined bus, rty retries, timeout under WB_REQ_MASTER_TIMEOUT_EN.
// Latency: strobe the cycle after the handshake; rsp_valid_o the cycle after the terminating ack/err/rty.
// Backpressure: req_ready_o only in IDLE; wb_stall_i holds the strobe; responses are never stalled.
module wb_req_master
    import wb_req_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    wb_req_master_if.master bus
);
    localparam int RW = cnt_width(MAX_RETRY);

    if (TIMEOUT < 1 || MAX_RETRY < 0) begin : g_bad_cfg
        $error("wb_req_master: TIMEOUT must be >= 1 and MAX_RETRY >= 0");
    end

    state_t                state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;
    logic [RW-1:0]         retry_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_dat_q;

    logic                  latch, retry_inc, rsp_set, rsp_err_d;
    logic [31:0]           rsp_dat_d;
    logic                  in_access, sampled, timeout_hit;

    assign in_access = (state_q == S_STROBE) || (state_q == S_WAIT);
    // Slave status only counts once the strobe has been taken.
    assign sampled   = (state_q == S_WAIT) || (state_q == S_STROBE && !bus.wb_stall_i);

`ifdef WB_REQ_MASTER_TIMEOUT_EN
    wb_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        latch     = 1'b0;
        retry_inc = 1'b0;
        rsp_set   = 1'b0;
        rsp_err_d = RSP_OK;
        rsp_dat_d = RSP_DAT_NONE;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    state_d = S_STROBE;
                    latch   = 1'b1;
                end
            end
            S_STROBE, S_WAIT: begin
                if (sampled && bus.wb_err_i) begin
                    state_d   = S_RESP;
                    rsp_set   = 1'b1;
                    rsp_err_d = RSP_ERR;
                end else if (sampled && bus.wb_ack_i) begin
                    state_d   = S_RESP;
                    rsp_set   = 1'b1;
                    rsp_dat_d = we_q ? RSP_DAT_NONE : bus.wb_dat_i;
                end else if (sampled && bus.wb_rty_i) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        state_d   = S_BACKOFF;
                        retry_inc = 1'b1;
                    end else begin
                        state_d   = S_RESP;
                        rsp_set   = 1'b1;
                        rsp_err_d = RSP_ERR;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_RESP;
                    rsp_set   = 1'b1;
                    rsp_err_d = RSP_ERR;
                end else if (sampled) begin
                    state_d = S_WAIT;
                end
            end
            S_BACKOFF: state_d = S_STROBE;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_q     <= '0;
            retry_q   <= '0;
            rsp_err_q <= RSP_OK;
            rsp_dat_q <= RSP_DAT_NONE;
        end else begin
            state_q <= state_d;
            if (latch) begin
                we_q    <= bus.req_we_i;
                adr_q   <= bus.req_adr_i;
                sel_q   <= bus.req_sel_i;
                dat_q   <= bus.req_dat_i;
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + RW'(1);
            end
            if (rsp_set) begin
                rsp_err_q <= rsp_err_d;
                rsp_dat_q <= rsp_dat_d;
            end
        end
    end

    // Ready is gated by reset so it reads low for as long as reset is held.
    assign bus.req_ready_o = rst_n_i && (state_q == S_IDLE);
    assign bus.wb_cyc_o    = in_access;
    assign bus.wb_stb_o    = (state_q == S_STROBE);
    assign bus.wb_we_o     = we_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_dat_o    = dat_q;
    assign bus.rsp_valid_o = (state_q == S_RESP);
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_dat_o   = rsp_dat_q;

endmodule

// File: doc/wb_req_master.md
WB_REQ_MASTER -- requirements
Module: wb_req_master

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to 4 and set the byte-address width of req_adr_i and wb_adr_o.
REQ-002 Parameter TIMEOUT SHALL default to 255 and set the cycle limit for one bus access.
REQ-003 Parameter MAX_RETRY SHALL default to 3 and set the retries allowed after wb_rty_i.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  single clock; all logic on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request offered.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_we_i  in  1  1=write, 0=read.
- req_adr_i  in  ADDR_WIDTH  byte address.
- req_sel_i  in  4  byte enables.
- req_dat_i  in  32  write data.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_err_o  out  1  response is an error; valid with rsp_valid_o.
- rsp_dat_o  out  32  read data; valid with rsp_valid_o.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  Wishbone pipelined master controls.
- wb_adr_o  out  ADDR_WIDTH;  wb_sel_o  out  4;  wb_dat_o  out  32.
- wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i  in  1  slave status.
- wb_dat_i  in  32  slave read data.

Function
REQ-005 The FSM SHALL have the states IDLE, STROBE, WAIT, BACKOFF and RESP.
REQ-006 req_ready_o SHALL be high only in IDLE; a handshake SHALL latch we/adr/sel/dat, clear the retry count and timer, and move to STROBE.
REQ-007 In STROBE, wb_cyc_o and wb_stb_o SHALL be high; on wb_stall_i=0 the FSM SHALL go to WAIT, otherwise it SHALL stay in STROBE.
REQ-008 In WAIT, wb_cyc_o SHALL be high and wb_stb_o low; exactly one strobe SHALL be issued per attempt.
REQ-009 A wb_ack_i/wb_err_i/wb_rty_i sampled in STROBE with wb_stall_i=0, or in WAIT, SHALL terminate the attempt.
- Priority is err > ack > rty.
REQ-010 On ack, the FSM SHALL go to RESP with rsp_err_o=0; on a read, rsp_dat_o SHALL capture wb_dat_i, and on a write it SHALL capture 0.
REQ-011 On err, the FSM SHALL go to RESP with rsp_err_o=1 and rsp_dat_o=0.
REQ-012 On rty with retry count < MAX_RETRY, the FSM SHALL increment the count and spend one cycle in BACKOFF with wb_cyc_o=0, then return to STROBE.
- With count = MAX_RETRY, it SHALL go to RESP with rsp_err_o=1.
REQ-013 RESP SHALL last exactly one cycle with rsp_valid_o=1, then return to IDLE; there is no response backpressure.
REQ-014 wb_adr_o/wb_sel_o/wb_we_o/wb_dat_o SHALL hold the latched values from STROBE through the end of WAIT.
REQ-015 Minimum latency SHALL be: handshake at cycle N, strobe at N+1, ack at N+1, rsp_valid_o at N+2.
REQ-016 wb_ack_i/wb_err_i/wb_rty_i outside STROBE/WAIT SHALL be ignored.

Reset
REQ-017 Asserting rst_n_i SHALL immediately force IDLE, clear the retry count and timer, drive all wb_* and rsp_* outputs to 0, and drive req_ready_o to 0 while held low.
REQ-018 Reset mid-access SHALL abandon the access without issuing any response; req_ready_o SHALL be 1 on the first clock after release.

Configuration
REQ-019 With macro WB_REQ_MASTER_TIMEOUT_EN defined:
- A counter SHALL count cycles spent in STROBE+WAIT per attempt.
- On reaching TIMEOUT, the FSM SHALL drop wb_cyc_o and go to RESP with rsp_err_o=1.
REQ-020 Without WB_REQ_MASTER_TIMEOUT_EN, no counter SHALL exist and an access SHALL wait indefinitely.

Structure
REQ-021 Package wb_req_master_pkg SHALL hold the state enum and the response-status constants.
REQ-022 The timeout counter SHALL be sub-module wb_req_timer (clear, enable, expired), instantiated only under WB_REQ_MASTER_TIMEOUT_EN.

Verification
REQ-023 Read: req adr=0x8, slave acks 2 cycles after strobe with 0xDEADBEEF -> one rsp_valid_o, rsp_dat_o=0xDEADBEEF, rsp_err_o=0.
REQ-024 Write: adr=0x4, dat=0x15, wb_stall_i high 3 cycles -> wb_stb_o high 4 cycles, a single strobe accepted, response rsp_err_o=0.
REQ-025 Retry: slave asserts rty 4 times -> 4 strobes, each separated by one wb_cyc_o=0 cycle, then rsp_err_o=1.
REQ-026 Timeout (macro on, TIMEOUT=16): slave never acks -> wb_cyc_o drops and rsp_err_o=1 at cycle 16 after strobe; with the macro off -> no response.
REQ-027 Reset: rst_n_i pulsed low while in WAIT -> outputs 0 immediately, no rsp_valid_o, req_ready_o=1 after release.
